i4003_driver: RTL and testbench
===============================

# i4003_driver

Hardware master for a daisy-chain of i4003 shift registers. Accepts a parallel word from the host side, then generates the chain's `cp` clock and serial data with i4003-compliant phase widths. Optionally captures the chain's previous contents from the last device's `serial_out`. Sits between a CPU-side I/O port and one or more cascaded i4003 instances, replacing software bit-banging of the shift clock.

## Interface

**Parameters**
- `SYSCLK_TCY`, default 20: system clock period in ns.
- `CHAIN_LEN`, default 1: number of cascaded i4003 devices; `NBITS = 10*CHAIN_LEN`.
- `CP_LOW_NS`, default 500: minimum `cp` low time in ns; must be > 250.
- `CP_HIGH_NS`, default 500: minimum `cp` high time in ns; must be > 250.

**Ports** (clock and reset first)
- `sysclk` in, 1: system clock. One clock domain; all logic is on its rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `start` in, 1: transfer request; sampled only while `busy`=0.
- `data` in, NBITS: word to load; `data[10k+9:10k]` ends up in device k (k=0 nearest the driver).
- `chain_out` in, 1: `serial_out` of the last device in the chain.
- `busy` out, 1: a transfer is in progress.
- `done` out, 1: one-cycle pulse at the end of a transfer.
- `cp` out, 1: shift clock to every device's `cp`.
- `sd` out, 1: serial data to device 0 `serial_in`.
- `enable` out, 1: drives every device's `enable`.
- `readback` out, NBITS: previous chain contents. Present only with `I4003_DRIVER_READBACK_EN`.

## Operation

- Cycle counts: `TL = max(1, ceil(CP_LOW_NS/SYSCLK_TCY))` and `TH = max(1, ceil(CP_HIGH_NS/SYSCLK_TCY))`. Counter widths are sized with `clog2`.
- Reset values: `busy`=0, `done`=0, `cp`=0, `sd`=0, `enable`=0, `readback`=0. Internal shift register and bit counter are cleared; the FSM enters IDLE.

**FSM states**
- **IDLE**
  - `cp`=0; `sd` holds its last value.
  - On `start`=1: latch `data`, load bit count NBITS, go to LOW.
- **LOW**
  - `cp`=0 and `sd` = current MSB of the shift register.
  - After TL cycles, go to HIGH.
- **HIGH**
  - `cp`=1 and `sd` is held.
  - After TH cycles: shift the register left, decrement the count.
  - If the count is now 0, go to TAIL; otherwise go to LOW.
- **TAIL**
  - `cp`=0 for TL cycles, which lets the chain's `serial_out` settle.
  - Then pulse `done`, go to IDLE.

**Bit order**
- MSB first: `data[NBITS-1]` is sent first and lands in device CHAIN_LEN-1 bit 9.
- `data[0]` is sent last and lands in device 0 bit 0.

**Other rules**
- `busy` is high from the cycle after `start` is accepted through the cycle `done` is high.
- `start` while `busy`=1 is ignored, not queued.
- `start` held high continuously begins a new transfer on the first IDLE cycle after `done`.
- `enable` is 0 from reset until the first `done`. After that it is 0 while `busy`=1 (outputs blanked during shifting) and 1 while idle.
- Reset mid-transfer: outputs return to reset values immediately, with no completion of the current `cp` pulse. The chain contents are partially shifted and undefined.

## Timing

- `sd` changes only on the same `sysclk` edge where `cp` falls, or on entry to LOW from IDLE. Setup to the `cp` rise is TL cycles; hold after the `cp` rise is TH cycles. Both exceed the i4003 250 ns internal delay.
- Transfer length from `start` accepted to the `done` cycle: `NBITS*(TL+TH) + TL + 1` cycles.
- `cp` produces exactly NBITS rising edges per transfer and never glitches. It is a registered output.

## Configuration

- `I4003_DRIVER_READBACK_EN` defined:
  - On each cycle where `cp` goes 0→1, sample `chain_out` into a readback shift register, MSB first.
  - At `done`, `readback` updates to the NBITS collected bits. These equal the chain contents before this transfer, in the same ordering as `data`.
  - `readback` is stable otherwise.
- Macro undefined: the `readback` port and its logic are absent, and `chain_out` is unused.

## Test plan

- **Single device**
  - Setup: CHAIN_LEN=1 with an i4003 model, SYSCLK_TCY=20 (TL=TH=25).
  - Stimulus: `start` with `data`=10'h2A5.
  - Required: `done` after 10*50+25+1 = 526 cycles, device `parallel_out`=10'h2A5, `enable`=1.
- **Chain ordering**
  - Setup: CHAIN_LEN=2.
  - Stimulus: `data`=20'hABCDE.
  - Required: device 0 shows 10'h0DE and device 1 shows 10'h2AF.
- **Readback**
  - Setup: READBACK_EN, CHAIN_LEN=2.
  - Stimulus: a transfer of 20'h12345, then a transfer of 20'hFFFFF.
  - Required: after the second `done`, `readback`=20'h12345.
- **Busy and enable behaviour**
  - Stimulus: `start` pulsed again mid-transfer.
  - Required: it is ignored, exactly 10 `cp` rises occur, and `enable`=0 throughout `busy`.
- **Phase widths**
  - Check: every `cp` high and low interval is ≥ 500 ns.
  - Check: `sd` never changes while `cp`=1.
- **Reset mid-transfer**
  - Stimulus: `rst_n` low during HIGH.
  - Required: `cp`, `busy` and `enable` are 0 in the same delta, with no `done`. After release, a new transfer completes correctly.

Source files
------------

// File: rtl/i4003_driver.sv
// i4003_driver: shift-clock and serial-data master for a daisy-chain of i4003
// shift registers. A parallel word is shifted out MSB first, with cp low and
// high phases stretched to whole sysclk cycles that are never shorter than
// CP_LOW_NS / CP_HIGH_NS.
// Optional feature: define I4003_DRIVER_READBACK_EN to add the readback port.
// It captures the chain's previous contents from chain_out while the new word
// is shifted in.
module i4003_driver #(
  parameter  int SYSCLK_TCY = 20,
  parameter  int CHAIN_LEN  = 1,
  parameter  int CP_LOW_NS  = 500,
  parameter  int CP_HIGH_NS = 500,
  localparam int NBITS      = 10 * CHAIN_LEN
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NBITS-1:0] data,
  input  logic             chain_out,
  output logic             busy,
  output logic             done,
  output logic             cp,
  output logic             sd,
  output logic             enable
`ifdef I4003_DRIVER_READBACK_EN
  ,
  output logic [NBITS-1:0] readback
`endif
);

  // Phase lengths in sysclk cycles, rounded up and at least one cycle.
  localparam int TL_CEIL = (CP_LOW_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
  localparam int TH_CEIL = (CP_HIGH_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
  localparam int TL      = (TL_CEIL < 1) ? 1 : TL_CEIL;
  localparam int TH      = (TH_CEIL < 1) ? 1 : TH_CEIL;
  localparam int TMAX    = (TL > TH) ? TL : TH;
  localparam int CW      = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW      = $clog2(NBITS + 1);

  // Phase counters count down from length-1 to zero.
  localparam logic [CW-1:0] TL_LOAD    = CW'(TL - 1);
  localparam logic [CW-1:0] TH_LOAD    = CW'(TH - 1);
  localparam logic [BW-1:0] NBITS_LOAD = BW'(NBITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_TAIL
  } state_t;

  state_t           state_q,  state_d;
  logic [CW-1:0]    phase_q,  phase_d;
  logic [BW-1:0]    bits_q,   bits_d;
  logic [NBITS-1:0] shreg_q,  shreg_d;
  logic             cp_q,     cp_d;
  logic             sd_q,     sd_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             enable_q, enable_d;
  // Set by the first completed transfer; enable stays low until then.
  logic             primed_q, primed_d;

`ifdef I4003_DRIVER_READBACK_EN
  logic [NBITS-1:0] rb_sh_q, rb_sh_d;
  logic [NBITS-1:0] rb_q,    rb_d;
`else
  // chain_out only matters when readback is built.
  logic unused_chain_out;
  assign unused_chain_out = chain_out;
`endif

  // Next-state, phase timing, shifting and next values of the registered outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d  = state_q;
    phase_d  = phase_q;
    bits_d   = bits_q;
    shreg_d  = shreg_q;
    cp_d     = cp_q;
    sd_d     = sd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef I4003_DRIVER_READBACK_EN
    rb_sh_d  = rb_sh_q;
    rb_d     = rb_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        cp_d   = 1'b0;
        busy_d = 1'b0;
        // busy_q is still high during the done cycle, so start is ignored there.
        if (start && !busy_q) begin
          shreg_d = data;
          bits_d  = NBITS_LOAD;
          phase_d = TL_LOAD;
          sd_d    = data[NBITS-1];
          busy_d  = 1'b1;
          state_d = S_LOW;
        end
      end

      S_LOW: begin
        if (phase_q == '0) begin
          phase_d = TH_LOAD;
          cp_d    = 1'b1;
          state_d = S_HIGH;
`ifdef I4003_DRIVER_READBACK_EN
          // chain_out still shows the bit the chain is about to shift out.
          rb_sh_d = {rb_sh_q[NBITS-2:0], chain_out};
`endif
        end else begin
          phase_d = phase_q - CW'(1);
        end
      end

      S_HIGH: begin
        if (phase_q == '0) begin
          shreg_d = {shreg_q[NBITS-2:0], 1'b0};
          bits_d  = bits_q - BW'(1);
          cp_d    = 1'b0;
          phase_d = TL_LOAD;
          if (bits_q == BW'(1)) begin
            state_d = S_TAIL;
          end else begin
            // sd moves only together with the falling edge of cp.
            sd_d    = shreg_q[NBITS-2];
            state_d = S_LOW;
          end
        end else begin
          phase_d = phase_q - CW'(1);
        end
      end

      S_TAIL: begin
        if (phase_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
`ifdef I4003_DRIVER_READBACK_EN
          rb_d    = rb_sh_q;
`endif
        end else begin
          phase_d = phase_q - CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    primed_d = primed_q | done_d;
    enable_d = primed_d & ~busy_d;
  end

  // State and registered outputs; everything clears immediately on reset.
  always_ff @(posedge sysclk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      bits_q   <= '0;
      // NOTE: the data shift register is only NBITS flops, so it takes the async reset like all other state.
      shreg_q  <= '0;
      cp_q     <= 1'b0;
      sd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      enable_q <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bits_q   <= bits_d;
      shreg_q  <= shreg_d;
      cp_q     <= cp_d;
      sd_q     <= sd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      enable_q <= enable_d;
      primed_q <= primed_d;
    end
  end

`ifdef I4003_DRIVER_READBACK_EN
  // Readback collection register and the word presented at done.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rb_sh_q <= '0;
      rb_q    <= '0;
    end else begin
      rb_sh_q <= rb_sh_d;
      rb_q    <= rb_d;
    end
  end

  assign readback = rb_q;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign cp     = cp_q;
  assign sd     = sd_q;
  assign enable = enable_q;

endmodule

// File: tb/tb_i4003_driver.sv
// Self-checking bench for i4003_driver with a two-device chain.
// A behavioural chain of i4003 shift registers sits on cp/sd/chain_out.
// The expected results come from the transfer rules:
//   - after a transfer, the chain holds the word that was sent;
//   - readback holds what the chain held before that transfer;
//   - the transfer length is NBITS*(TL+TH)+TL+1 cycles;
//   - cp makes NBITS rising edges, and the phase widths are at least the
//     minimum times.
`timescale 1ns/1ps
module tb_i4003_driver;

  localparam int SYSCLK_TCY = 20;
  localparam int CHAIN_LEN  = 2;
  localparam int CP_LOW_NS  = 500;
  localparam int CP_HIGH_NS = 500;
  localparam int NBITS      = 10 * CHAIN_LEN;
  localparam int TL         = (CP_LOW_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
  localparam int TH         = (CP_HIGH_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
  localparam int XFER       = NBITS * (TL + TH) + TL + 1;
  localparam int NO_RUN     = 1_000_000;

  logic             sysclk = 1'b0;
  logic             rst_n  = 1'b0;
  logic             start  = 1'b0;
  logic [NBITS-1:0] data   = '0;
  logic             chain_out;
  logic             busy, done, cp, sd, enable;
`ifdef I4003_DRIVER_READBACK_EN
  logic [NBITS-1:0] readback;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #(SYSCLK_TCY / 2) sysclk = ~sysclk;

  i4003_driver #(
    .SYSCLK_TCY(SYSCLK_TCY),
    .CHAIN_LEN (CHAIN_LEN),
    .CP_LOW_NS (CP_LOW_NS),
    .CP_HIGH_NS(CP_HIGH_NS)
  ) u_dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .start    (start),
    .data     (data),
    .chain_out(chain_out),
    .busy     (busy),
    .done     (done),
    .cp       (cp),
    .sd       (sd),
    .enable   (enable)
`ifdef I4003_DRIVER_READBACK_EN
    ,
    .readback (readback)
`endif
  );

  // Behavioural chain of i4003 devices: device k holds chain[10k+9:10k].
  logic [NBITS-1:0] chain = '0;
  always @(posedge cp) chain <= {chain[NBITS-2:0], sd};
  assign chain_out = chain[NBITS-1];

  // Protocol monitor, sampling on the falling sysclk edge.
  int   cp_rises         = 0;
  int   done_pulses      = 0;
  int   sd_changes_high  = 0;
  int   enable_busy_hits = 0;
  int   min_high_run     = NO_RUN;
  int   min_low_run      = NO_RUN;
  int   run_len          = 0;
  logic prev_cp          = 1'b0;
  logic prev_sd          = 1'b0;

  always @(negedge sysclk) begin
    if (!rst_n) begin
      run_len = 0;
    end else begin
      if (cp !== prev_cp) begin
        if (prev_cp === 1'b1) begin
          if (run_len < min_high_run) min_high_run = run_len;
        end else begin
          cp_rises++;
          if (run_len < min_low_run) min_low_run = run_len;
        end
        run_len = 1;
      end else begin
        run_len++;
      end
      if (cp === 1'b1 && sd !== prev_sd) sd_changes_high++;
      if (busy === 1'b1 && enable !== 1'b0) enable_busy_hits++;
      if (done === 1'b1) done_pulses++;
    end
    prev_cp = cp;
    prev_sd = sd;
  end

  // Watchdog: the run must never hang.
  initial begin
    #(SYSCLK_TCY * 200000);
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Launch one transfer and return the cycle (counted from acceptance) where done is seen.
  // A second start can optionally be pulsed while the transfer is busy.
  // lat stays -1 if done never arrives within the budget.
  task automatic run_transfer(input logic [NBITS-1:0] d, input int poke_at,
                              input logic [NBITS-1:0] poke_d, output int lat);
    int n;
    @(negedge sysclk);
    data  = d;
    start = 1'b1;
    n     = 0;
    lat   = -1;
    while (n < XFER + 50 && lat < 0) begin
      @(negedge sysclk);
      n++;
      if (n == 1) start = 1'b0;
      if (poke_at != 0 && n == poke_at) begin
        start = 1'b1;
        data  = poke_d;
      end
      if (poke_at != 0 && n == poke_at + 1) begin
        start = 1'b0;
        data  = d;
      end
      if (done === 1'b1) lat = n;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    data  = '0;
    repeat (3) @(negedge sysclk);
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (cp !== 1'b0)     begin n_bad++; $display("FAIL reset_cp: got %b want 0", cp); end
    n_cmp++; if (sd !== 1'b0)     begin n_bad++; $display("FAIL reset_sd: got %b want 0", sd); end
    n_cmp++; if (enable !== 1'b0) begin n_bad++; $display("FAIL reset_enable: got %b want 0", enable); end
`ifdef I4003_DRIVER_READBACK_EN
    n_cmp++; if (readback !== '0) begin n_bad++; $display("FAIL reset_readback: got %h want 0", readback); end
`endif
    rst_n = 1'b1;
    repeat (4) @(negedge sysclk);
    n_cmp++; if (enable !== 1'b0) begin n_bad++; $display("FAIL enable_before_first_done: got %b want 0", enable); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL idle_busy_after_reset: got %b want 0", busy); end
  endtask

  task automatic test_chain_ordering();
    int lat;
    run_transfer(20'hABCDE, 0, '0, lat);
    n_cmp++; if (lat !== XFER) begin n_bad++; $display("FAIL order_latency: got %0d want %0d", lat, XFER); end
    n_cmp++; if (chain[9:0] !== 10'h0DE)   begin n_bad++; $display("FAIL order_dev0: got %h want 0de", chain[9:0]); end
    n_cmp++; if (chain[19:10] !== 10'h2AF) begin n_bad++; $display("FAIL order_dev1: got %h want 2af", chain[19:10]); end
    @(negedge sysclk);
    n_cmp++; if (enable !== 1'b1) begin n_bad++; $display("FAIL order_enable_after_done: got %b want 1", enable); end
  endtask

`ifdef I4003_DRIVER_READBACK_EN
  task automatic test_readback();
    int lat;
    run_transfer(20'h12345, 0, '0, lat);
    n_cmp++; if (lat !== XFER) begin n_bad++; $display("FAIL rb_first_latency: got %0d want %0d", lat, XFER); end
    n_cmp++; if (readback !== 20'hABCDE) begin n_bad++; $display("FAIL rb_first: got %h want abcde", readback); end
    run_transfer(20'hFFFFF, 0, '0, lat);
    n_cmp++; if (lat !== XFER) begin n_bad++; $display("FAIL rb_second_latency: got %0d want %0d", lat, XFER); end
    n_cmp++; if (readback !== 20'h12345) begin n_bad++; $display("FAIL rb_second: got %h want 12345", readback); end
    repeat (5) @(negedge sysclk);
    n_cmp++; if (readback !== 20'h12345) begin n_bad++; $display("FAIL rb_stable: got %h want 12345", readback); end
  endtask
`endif

  task automatic test_random_transfers();
    logic [NBITS-1:0] d;
    logic [NBITS-1:0] prev;
    int lat;
    int rises0;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       d = '0;
        1:       d = 20'hFFFFF;
        default: d = NBITS'($urandom);
      endcase
      repeat ($urandom_range(0, 5)) @(negedge sysclk);
      prev   = chain;
      rises0 = cp_rises;
      run_transfer(d, 0, '0, lat);
      n_cmp++; if (lat !== XFER) begin n_bad++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, XFER); end
      n_cmp++; if (chain !== d)  begin n_bad++; $display("FAIL rand%0d_chain: got %h want %h", i, chain, d); end
      n_cmp++; if (cp_rises - rises0 !== NBITS) begin n_bad++; $display("FAIL rand%0d_cp_rises: got %0d want %0d", i, cp_rises - rises0, NBITS); end
`ifdef I4003_DRIVER_READBACK_EN
      n_cmp++; if (readback !== prev) begin n_bad++; $display("FAIL rand%0d_readback: got %h want %h", i, readback, prev); end
`endif
      @(negedge sysclk);
      n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL rand%0d_busy_after: got %b want 0", i, busy); end
      n_cmp++; if (enable !== 1'b1) begin n_bad++; $display("FAIL rand%0d_enable_after: got %b want 1", i, enable); end
    end
  endtask

  task automatic test_busy_enable();
    logic [NBITS-1:0] d;
    int lat;
    int rises0;
    int hits0;
    d      = NBITS'($urandom);
    rises0 = cp_rises;
    hits0  = enable_busy_hits;
    run_transfer(d, 400, ~d, lat);
    n_cmp++; if (lat !== XFER) begin n_bad++; $display("FAIL busy_latency: got %0d want %0d", lat, XFER); end
    n_cmp++; if (chain !== d)  begin n_bad++; $display("FAIL busy_ignored_start: got %h want %h", chain, d); end
    n_cmp++; if (cp_rises - rises0 !== NBITS) begin n_bad++; $display("FAIL busy_cp_rises: got %0d want %0d", cp_rises - rises0, NBITS); end
    n_cmp++; if (enable_busy_hits !== hits0) begin n_bad++; $display("FAIL busy_enable_high: got %0d cycles want 0", enable_busy_hits - hits0); end
    repeat (2) @(negedge sysclk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_not_queued: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [NBITS-1:0] d1;
    logic [NBITS-1:0] d2;
    int n;
    int lat1;
    int lat2;
    d1 = NBITS'($urandom);
    d2 = ~d1;
    @(negedge sysclk);
    data  = d1;
    start = 1'b1;
    n     = 0;
    lat1  = -1;
    lat2  = -1;
    while (n < 2 * XFER + 50 && lat2 < 0) begin
      @(negedge sysclk);
      n++;
      if (n == 1) data = d2;
      if (done === 1'b1) begin
        if (lat1 < 0) begin
          lat1 = n;
          n_cmp++; if (chain !== d1) begin n_bad++; $display("FAIL b2b_first_chain: got %h want %h", chain, d1); end
        end else begin
          lat2 = n;
        end
      end
      if (lat1 > 0 && n == lat1 + 1) begin
        n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL b2b_gap_busy: got %b want 0", busy); end
        n_cmp++; if (enable !== 1'b1) begin n_bad++; $display("FAIL b2b_gap_enable: got %b want 1", enable); end
      end
    end
    start = 1'b0;
    n_cmp++; if (lat1 !== XFER)         begin n_bad++; $display("FAIL b2b_first_latency: got %0d want %0d", lat1, XFER); end
    n_cmp++; if (lat2 !== 2 * XFER + 1) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want %0d", lat2, 2 * XFER + 1); end
    n_cmp++; if (chain !== d2)          begin n_bad++; $display("FAIL b2b_second_chain: got %h want %h", chain, d2); end
    repeat (3) @(negedge sysclk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_stops: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [NBITS-1:0] d;
    logic [NBITS-1:0] prev;
    int n;
    int lat;
    int dones0;
    d = NBITS'($urandom);
    @(negedge sysclk);
    data  = d;
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    n = 0;
    while (n < XFER && cp !== 1'b1) begin
      @(negedge sysclk);
      n++;
    end
    n_cmp++; if (cp !== 1'b1) begin n_bad++; $display("FAIL mid_reach_high: got cp=%b want 1", cp); end
    repeat (3) @(negedge sysclk);
    dones0 = done_pulses;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cp !== 1'b0)     begin n_bad++; $display("FAIL mid_cp: got %b want 0", cp); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (enable !== 1'b0) begin n_bad++; $display("FAIL mid_enable: got %b want 0", enable); end
    n_cmp++; if (done !== 1'b0)   begin n_bad++; $display("FAIL mid_done: got %b want 0", done); end
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (5) @(negedge sysclk);
    n_cmp++; if (done_pulses !== dones0) begin n_bad++; $display("FAIL mid_no_done: got %0d pulses want 0", done_pulses - dones0); end
    n_cmp++; if (enable !== 1'b0) begin n_bad++; $display("FAIL mid_enable_rearm: got %b want 0", enable); end
    d    = NBITS'($urandom);
    prev = chain;
    run_transfer(d, 0, '0, lat);
    n_cmp++; if (lat !== XFER) begin n_bad++; $display("FAIL mid_recover_latency: got %0d want %0d", lat, XFER); end
    n_cmp++; if (chain !== d)  begin n_bad++; $display("FAIL mid_recover_chain: got %h want %h", chain, d); end
`ifdef I4003_DRIVER_READBACK_EN
    n_cmp++; if (readback !== prev) begin n_bad++; $display("FAIL mid_recover_readback: got %h want %h", readback, prev); end
`endif
    @(negedge sysclk);
    n_cmp++; if (enable !== 1'b1) begin n_bad++; $display("FAIL mid_recover_enable: got %b want 1", enable); end
  endtask

  task automatic test_phase_widths();
    n_cmp++; if (min_high_run == NO_RUN || !(min_high_run * SYSCLK_TCY >= CP_HIGH_NS)) begin
      n_bad++; $display("FAIL phase_high_min: got %0d cycles want >= %0d ns", min_high_run, CP_HIGH_NS);
    end
    n_cmp++; if (min_low_run == NO_RUN || !(min_low_run * SYSCLK_TCY >= CP_LOW_NS)) begin
      n_bad++; $display("FAIL phase_low_min: got %0d cycles want >= %0d ns", min_low_run, CP_LOW_NS);
    end
    n_cmp++; if (sd_changes_high !== 0) begin n_bad++; $display("FAIL sd_stable_while_cp_high: got %0d changes want 0", sd_changes_high); end
    n_cmp++; if (enable_busy_hits !== 0) begin n_bad++; $display("FAIL enable_low_while_busy: got %0d cycles want 0", enable_busy_hits); end
  endtask

  initial begin
    test_reset();
    test_chain_ordering();
`ifdef I4003_DRIVER_READBACK_EN
    test_readback();
`endif
    test_random_transfers();
    test_busy_enable();
    test_back_to_back();
    test_reset_mid();
    test_phase_widths();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
